// File: rtl/cdc_req_arbiter.sv
// Source-domain side of a shared bundled-data CDC channel: round-robin arbitration
// across requesters, a stable payload register, and a 4-phase req/ack sequencer with timeout.
module cdc_req_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_REQ-1:0]           req_valid_i,
   input  logic [N_REQ*W-1:0]         req_data_i,
   output logic [N_REQ-1:0]           req_ready_o,
   output logic [W-1:0]               cdc_data_o,
   output logic [$clog2(N_REQ)-1:0]   cdc_id_o,
   output logic                       cdc_req_o,
   input  logic                       cdc_ack_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       timeout_o,
   output logic [1:0]                 dbg_state_o,
   output logic [$clog2(N_REQ)-1:0]   dbg_ptr_o
);

   // Handshake: requester k transfers when req_valid_i[k] & req_ready_o[k] at a rising
   // edge; ready is never held off by valid and at most one ready bit is set per cycle.

   localparam int IW = $clog2(N_REQ);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_ACK  = 2'd1,
      S_WAIT_NACK = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [W-1:0]    data_q, data_d;
   logic [IW-1:0]   id_q, id_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            req_q, req_d;
   logic            done_q, done_d;
   logic            timeout_q, timeout_d;
   logic            abandoned_q, abandoned_d;

   logic            found;
   logic [IW-1:0]   grant;
   logic            accept;

   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_valid_i[(int'(ptr_q) + i) % N_REQ]) begin
            found = 1'b1;
            grant = IW'((int'(ptr_q) + i) % N_REQ);
         end
      end
   end

   // A lingering ack in IDLE (spurious or from an abandoned transfer) blocks new accepts.
   assign accept = (state_q == S_IDLE) && !cdc_ack_i && !rst_i && found;

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[grant] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      data_d      = data_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      abandoned_d = abandoned_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d      = req_data_i[int'(grant)*W +: W];
               id_d        = grant;
               ptr_d       = (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
               cnt_d       = '0;
               abandoned_d = 1'b0;
               req_d       = 1'b1;
               state_d     = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (cdc_ack_i) begin
               req_d   = 1'b0;
               state_d = S_WAIT_NACK;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               req_d       = 1'b0;
               timeout_d   = 1'b1;
               abandoned_d = 1'b1;
               state_d     = S_WAIT_NACK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_NACK: begin
            if (!cdc_ack_i) begin
               done_d  = !abandoned_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         data_q      <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         req_q       <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         abandoned_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         data_q      <= data_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         abandoned_q <= abandoned_d;
      end
   end

   assign cdc_data_o  = data_q;
   assign cdc_id_o    = id_q;
   assign cdc_req_o   = req_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign timeout_o   = timeout_q;
   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Directed bench for cdc_req_arbiter: single transfer, fairness, timeout, ack/expiry race,
// spurious ack in IDLE and reset mid-transfer, all against hand-computed values.
module tb_cdc_req_arbiter;

   localparam int N = 4;
   localparam int W = 32;
   localparam int TO = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   cdc_data;
   logic [1:0]     cdc_id;
   logic           cdc_req;
   logic           cdc_ack;
   logic           busy;
   logic           done;
   logic           timeout;
   logic [1:0]     dbg_state;
   logic [1:0]     dbg_ptr;

   int checks = 0;
   int failures = 0;
   int done_cnt;
   int to_cnt;

   cdc_req_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .cdc_data_o  (cdc_data),
      .cdc_id_o    (cdc_id),
      .cdc_req_o   (cdc_req),
      .cdc_ack_i   (cdc_ack),
      .busy_o      (busy),
      .done_o      (done),
      .timeout_o   (timeout),
      .dbg_state_o (dbg_state),
      .dbg_ptr_o   (dbg_ptr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are changed 1 time unit after the rising edge, outputs checked 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      cdc_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_slot(input int k, input logic [W-1:0] v);
      req_data[k*W +: W] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with every requester valid to prove ready stays low during reset.
      rst = 1'b1;
      req_valid = 4'b1111;
      req_data = '0;
      cdc_ack = 1'b0;
      tick();
      tick();
      settle();
      check("rst_ready", req_ready, 0);
      check("rst_req", cdc_req, 0);
      check("rst_data", cdc_data, 0);
      check("rst_id", cdc_id, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_ptr", dbg_ptr, 0);

      // Single transfer from requester 2: ack high cycles 4..7, done expected at cycle 9.
      rst = 1'b0;
      req_valid = 4'b0100;
      set_slot(2, 32'hDEADBEEF);
      settle();
      check("t1_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      done_cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         cdc_ack = (c >= 4 && c <= 7);
         settle();
         check("t1_req", cdc_req, (c >= 1 && c <= 4));
         check("t1_data", cdc_data, 32'hDEADBEEF);
         check("t1_id", cdc_id, 2);
         check("t1_done", done, (c == 9));
         if (done) done_cnt++;
         tick();
      end
      check("t1_done_count", done_cnt, 1);
      check("t1_busy_after", busy, 0);

      // Fairness with all requesters valid and an ack that follows req with no delay.
      do_reset();
      for (int k = 0; k < N; k++) set_slot(k, 32'hA0 + k);
      req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         cdc_ack = 1'b0;
         settle();
         check("fair_ready", req_ready, 4'b0001 << (i % N));
         if (i > 0) check("fair_done", done, 1);
         tick();
         cdc_ack = 1'b1;
         settle();
         check("fair_ready_busy", req_ready, 0);
         check("fair_req", cdc_req, 1);
         check("fair_id", cdc_id, i % N);
         check("fair_data", cdc_data, 32'hA0 + (i % N));
         tick();
         cdc_ack = 1'b0;
         settle();
         check("fair_req_low", cdc_req, 0);
         check("fair_ready_nack", req_ready, 0);
         tick();
      end

      // Timeout: ack stuck low, then a late ack pulse during WAIT_NACK, then a new accept.
      do_reset();
      set_slot(0, 32'h1111_0000);
      set_slot(1, 32'h2222_0001);
      req_valid = 4'b0001;
      settle();
      check("to_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      done_cnt = 0;
      to_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         cdc_ack = (c == 9 || c == 10);
         if (c >= 9) req_valid = 4'b0010;
         settle();
         check("to_req", cdc_req, (c <= 8));
         check("to_pulse", timeout, (c == 9));
         check("to_busy", busy, (c <= 11));
         if (c >= 9) check("to_ready_hold", req_ready, (c == 12) ? 4'b0010 : 4'b0000);
         if (done) done_cnt++;
         if (timeout) to_cnt++;
         if (c < 12) tick();
      end
      check("to_no_done", done_cnt, 0);
      check("to_count", to_cnt, 1);
      tick();
      req_valid = '0;
      settle();
      check("to_next_req", cdc_req, 1);
      check("to_next_id", cdc_id, 1);
      check("to_next_data", cdc_data, 32'h2222_0001);

      // Ack rises in the 8th WAIT_ACK cycle, exactly when the counter would expire.
      do_reset();
      set_slot(3, 32'h3333_3333);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      to_cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         cdc_ack = (c == 8);
         settle();
         check("race_req", cdc_req, (c <= 8));
         check("race_done", done, (c == 10));
         if (timeout) to_cnt++;
         tick();
      end
      check("race_no_timeout", to_cnt, 0);
      check("race_busy", busy, 0);

      // Spurious ack in IDLE with requester 1 valid: accept only once ack is low.
      do_reset();
      set_slot(1, 32'h5555_AAAA);
      req_valid = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         cdc_ack = 1'b1;
         settle();
         check("spur_ready", req_ready, 0);
         check("spur_busy", busy, 0);
         tick();
      end
      cdc_ack = 1'b0;
      settle();
      check("spur_ready_low", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      settle();
      check("spur_req", cdc_req, 1);
      check("spur_id", cdc_id, 1);

      // Reset one cycle into WAIT_ACK, then requesters 0 and 3 both valid.
      do_reset();
      set_slot(1, 32'h7777_7777);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      settle();
      check("mid_req_pre", cdc_req, 1);
      rst = 1'b1;
      tick();
      settle();
      check("mid_req", cdc_req, 0);
      check("mid_data", cdc_data, 0);
      check("mid_busy", busy, 0);
      check("mid_ptr", dbg_ptr, 0);
      check("mid_done", done, 0);
      check("mid_timeout", timeout, 0);
      rst = 1'b0;
      req_valid = 4'b1001;
      set_slot(0, 32'h0BAD_0000);
      settle();
      check("mid_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      settle();
      check("mid_id", cdc_id, 0);
      check("mid_next_data", cdc_data, 32'h0BAD_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cdc_req_arbiter.md
# cdc_req_arbiter

Source-domain controller that shares one bundled-data clock-domain crossing channel between `N_REQ` requesters. It round-robin arbitrates, holds the winning payload stable on `cdc_data_o`, and sequences a 4-phase req/ack handshake. The returning ack arrives through a two-stage synchronizer pipeline instantiated outside this block. A timeout abandons transfers the far side never acknowledges, so one dead destination cannot wedge every requester.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2.
- `W`, 32: payload width.
- `TIMEOUT`, 1024: max cycles spent waiting for ack high; 0 disables timeout.

Ports:
- `clk_i` input 1: single clock; all logic is rising-edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_valid_i` input `N_REQ`: per-requester payload valid.
- `req_data_i` input `N_REQ*W`: flattened payloads; requester k occupies bits `[k*W +: W]`.
- `req_ready_o` output `N_REQ`: one-hot accept; transfer occurs on valid&ready.
- `cdc_data_o` output `W`: registered payload; stable from accept until the next accept.
- `cdc_id_o` output `$clog2(N_REQ)`: registered index of the requester that owns `cdc_data_o`.
- `cdc_req_o` output 1: registered handshake request level.
- `cdc_ack_i` input 1: ack level, already synchronized into `clk_i`.
- `busy_o` output 1: high whenever the state is not IDLE.
- `done_o` output 1: one-cycle pulse when a handshake completes with ack.
- `timeout_o` output 1: one-cycle pulse when a transfer is abandoned.

## Operation
- States:
  - IDLE: no transfer in progress.
  - WAIT_ACK: `cdc_req_o`=1.
  - WAIT_NACK: `cdc_req_o`=0, waiting for ack to drop.
- Arbitration:
  - Round-robin pointer `ptr`, reset to 0.
  - Grant g is the first index with `req_valid_i` set, searching `ptr`, `ptr+1`, … mod `N_REQ`.
  - On accept, `ptr` becomes `(g+1) mod N_REQ`.
- `req_ready_o[g]` is combinational. It is 1 only when state=IDLE, `cdc_ack_i`=0, `rst_i`=0, and g is the grant; all other bits are 0.
- Accept, from IDLE:
  - Latch `req_data_i[g]` into `cdc_data_o` and g into `cdc_id_o`.
  - Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - If `cdc_ack_i`=1: go to WAIT_NACK (req drops).
  - Else, if `TIMEOUT`≠0 and this is the `TIMEOUT`-th consecutive WAIT_ACK cycle: go to WAIT_NACK and pulse `timeout_o` next cycle.
  - Else: increment the counter.
  - Ack and expiry in the same cycle: ack wins, no `timeout_o`.
- WAIT_NACK:
  - When `cdc_ack_i`=0: go to IDLE.
  - Pulse `done_o` on that transition, unless the transfer was abandoned by timeout.
  - There is no timeout in this state; the protocol must return to ack low before reuse.
- Ack high while in IDLE (spurious or late from an abandoned transfer): nothing is accepted until it drops; no error is flagged.
- `cdc_data_o` and `cdc_id_o` change only on accept, so they are stable for the whole req-high and req-low phases.
- Counter width: `$clog2(TIMEOUT+1)`; it never wraps.

## Timing
- Reset values (cycle after `rst_i` sampled high):
  - state IDLE, `ptr`=0.
  - `cdc_req_o`=0, `cdc_data_o`=0, `cdc_id_o`=0.
  - `busy_o`=0, `done_o`=0, `timeout_o`=0.
  - `req_ready_o`=0 while `rst_i`=1.
- Reset mid-transfer: aborts immediately; `cdc_req_o` drops the next cycle; no `done_o` and no `timeout_o`. The far domain must be reset in step.
- Accept sampled at cycle 0 gives `cdc_req_o`=1 and `busy_o`=1 at cycle 1.
- Ack sampled high at cycle k gives `cdc_req_o`=0 at k+1.
- Ack sampled low in WAIT_NACK at cycle m gives IDLE and `done_o`=1 at m+1. A new accept is possible in cycle m+1.
- Minimum accept-to-accept spacing is 3 cycles; with instant ack: accept, WAIT_ACK, WAIT_NACK, IDLE.
- Timeout: accept at cycle 0 with ack held low gives `cdc_req_o`=0 and `timeout_o`=1 at cycle `TIMEOUT`+1.

## Test plan
- Single transfer: requester 2 valid with 0xDEADBEEF; ack returns 3 cycles after req rises and drops 3 cycles after req falls. Required: `cdc_data_o`=0xDEADBEEF and `cdc_id_o`=2 throughout, one `done_o`, `busy_o` low afterwards.
- Fairness: all 4 requesters valid continuously with an instant-ack model. Required: grant order 0,1,2,3,0,1; `req_ready_o` always one-hot.
- Timeout with `TIMEOUT`=8 and ack stuck low. Required: `cdc_req_o` high for cycles 1–8, low at 9, `timeout_o` at 9, no `done_o`. Then a late ack pulse (high 2 cycles, then low) must complete back to IDLE, and the next request is then accepted.
- Ack and expiry coincide: ack rises in the 8th WAIT_ACK cycle. Required: `done_o` after ack falls, no `timeout_o`.
- Spurious ack high in IDLE with requester 1 valid. Required: `req_ready_o`=0 until ack falls; accept in the first cycle with ack low.
- Reset asserted one cycle into WAIT_ACK. Required: next cycle `cdc_req_o`=0, `cdc_data_o`=0, `busy_o`=0, `ptr`=0; with requesters 0 and 3 valid afterwards, requester 0 is granted first.
